// File: rtl/rom_seq_reader.sv
// rom_seq_reader: walks a range of ROM addresses on a start command and
// presents each registered word on a valid/ready stream.
// Optional feature macro: ROM_CHECKSUM_EN adds a running checksum output (csum).
module rom_seq_reader #(
    parameter int AW    = 4,
    parameter int DW    = 10,
    parameter int DEPTH = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   count,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    output logic          rom_rd_en,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          err
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [DW-1:0] csum
`endif
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, OUT, FIN} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] addr;
    logic [AW:0]   remaining;
    logic          accept, reject, hshk, more;

    // rom_addr follows the burst pointer; the pointer only moves on the way
    // into ISSUE, so the address holds steady in every other state
    assign rom_addr = addr;
    assign more     = (remaining > ONE);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state logic and ROM strobes
    always_comb begin
        state_nx  = state;
        rom_cs    = 1'b0;
        rom_rd_en = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        hshk      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count == '0 || base_addr > LAST) begin
                        reject = 1'b1;
                    end else begin
                        accept   = 1'b1;
                        state_nx = ISSUE;
                    end
                end
            end
            ISSUE: begin
                rom_cs    = 1'b1;
                rom_rd_en = 1'b1;
                state_nx  = OUT;
            end
            OUT: begin
                // out_valid is always high in OUT, so ready alone completes the handshake
                if (out_ready) begin
                    hshk     = 1'b1;
                    state_nx = more ? ISSUE : FIN;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // burst datapath: pointer, word count, output register and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= (state == FIN);
            err  <= reject;
            if (accept) begin
                addr      <= base_addr;
                remaining <= count;
                busy      <= 1'b1;
            end
            if (state == ISSUE) begin
                out_data  <= rom_data;
                out_valid <= 1'b1;
            end
            if (hshk) begin
                out_valid <= 1'b0;
                remaining <= remaining - ONE;
                if (more) addr <= (addr == LAST) ? '0 : addr + 1'b1;
            end
            if (state == FIN) busy <= 1'b0;
        end
    end

`ifdef ROM_CHECKSUM_EN
    // running sum of handshaked words, cleared when a new burst is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    csum <= '0;
        else if (accept) csum <= '0;
        else if (hshk)   csum <= csum + out_data;
    end
`endif

endmodule

// File: tb/tb_rom_seq_reader.sv
// Directed bench for rom_seq_reader; ROM model mem[i] = 10'h100 + i.
// Builds with or without ROM_CHECKSUM_EN.
module tb_rom_seq_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] base_addr;
    logic [4:0] count;
    logic [3:0] rom_addr;
    logic       rom_cs, rom_rd_en;
    logic [9:0] rom_data;
    logic [9:0] out_data;
    logic       out_valid, out_ready;
    logic       busy, done, err;
`ifdef ROM_CHECKSUM_EN
    logic [9:0] csum;
`endif

    int checks   = 0;
    int failures = 0;

    logic [3:0] addr_q[$];
    logic [9:0] data_q[$];
    int done_cnt = 0, err_cnt = 0, cs_cnt = 0, both_cnt = 0;

    rom_seq_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_rd_en(rom_rd_en), .rom_data(rom_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err)
`ifdef ROM_CHECKSUM_EN
        , .csum(csum)
`endif
    );

    always #5 clk = ~clk;

    // ROM model, combinational
    assign rom_data = (rom_addr < 4'd10) ? (10'h100 + 10'(rom_addr)) : 10'h000;

    // monitor on the falling edge
    always @(negedge clk) begin
        if (rom_cs) begin
            addr_q.push_back(rom_addr);
            cs_cnt++;
        end
        if (out_valid && out_ready) data_q.push_back(out_data);
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b0;
        #23;
        checks++;
        if ({rom_addr, rom_cs, rom_rd_en, out_data, out_valid, busy, done, err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got addr=%0d cs=%b data=%h v=%b busy=%b done=%b err=%b want all 0",
                     rom_addr, rom_cs, out_data, out_valid, busy, done, err);
        end
`ifdef ROM_CHECKSUM_EN
        checks++;
        if (csum !== 10'h000) begin failures++; $display("FAIL reset_csum got %h want 000", csum); end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b1; base_addr = 4'd3; count = 5'd1; start = 1'b1;
        tick();                   // N+1: ISSUE
        start = 1'b0;
        checks++;
        if (rom_cs !== 1'b1 || rom_rd_en !== 1'b1 || rom_addr !== 4'd3 || busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_issue got cs=%b rd=%b addr=%0d busy=%b v=%b want 1 1 3 1 0",
                     rom_cs, rom_rd_en, rom_addr, busy, out_valid);
        end
        tick();                   // N+2: OUT
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'h103 || rom_cs !== 1'b0) begin
            failures++;
            $display("FAIL single_out got v=%b data=%h cs=%b want 1 103 0", out_valid, out_data, rom_cs);
        end
        tick();                   // N+3: FIN
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_fin got v=%b done=%b busy=%b want 0 0 1", out_valid, done, busy);
        end
        tick();                   // N+4: done pulse
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_done got done=%b busy=%b want 1 0", done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got done=%b want 0", done); end
    endtask

    task automatic test_wrap();
        logic [3:0] ea[4];
        logic [9:0] ed[4];
        int a0, d0;
        bit ok;
        ea = '{4'd8, 4'd9, 4'd0, 4'd1};
        ed = '{10'h108, 10'h109, 10'h100, 10'h101};
        a0 = addr_q.size(); d0 = data_q.size();
        out_ready = 1'b1; base_addr = 4'd8; count = 5'd4; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(40, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL wrap_timeout got no done want done"); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL wrap_busy got %b want 0", busy); end
`ifdef ROM_CHECKSUM_EN
        checks++;
        if (csum !== 10'h012) begin failures++; $display("FAIL wrap_csum got %h want 012", csum); end
`endif
        checks++;
        if (addr_q.size() - a0 != 4 || data_q.size() - d0 != 4) begin
            failures++;
            $display("FAIL wrap_len got addrs=%0d words=%0d want 4 4", addr_q.size() - a0, data_q.size() - d0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (addr_q[a0+i] !== ea[i] || data_q[d0+i] !== ed[i]) begin
                    failures++;
                    $display("FAIL wrap_word%0d got addr=%0d data=%h want %0d %h",
                             i, addr_q[a0+i], data_q[d0+i], ea[i], ed[i]);
                end
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        int d0, c0;
        bit ok;
        d0 = data_q.size(); c0 = cs_cnt;
        out_ready = 1'b0; base_addr = 4'd0; count = 5'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 10'h100 || rom_cs !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d got v=%b data=%h cs=%b want 1 100 0", i, out_valid, out_data, rom_cs);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();                   // handshake done, second ISSUE
        checks++;
        if (rom_cs !== 1'b1 || rom_addr !== 4'd1) begin
            failures++;
            $display("FAIL bp_reissue got cs=%b addr=%0d want 1 1", rom_cs, rom_addr);
        end
        wait_done(20, ok);
        checks++;
        if (!ok || data_q.size() - d0 != 2 || cs_cnt - c0 != 2) begin
            failures++;
            $display("FAIL bp_burst got done=%b words=%0d issues=%0d want 1 2 2", ok, data_q.size() - d0, cs_cnt - c0);
        end else begin
            checks++;
            if (data_q[d0] !== 10'h100 || data_q[d0+1] !== 10'h101) begin
                failures++;
                $display("FAIL bp_data got %h %h want 100 101", data_q[d0], data_q[d0+1]);
            end
        end
        tick();
    endtask

    task automatic test_illegal();
        int c0;
        c0 = cs_cnt;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            base_addr = (k == 0) ? 4'd2 : 4'd12;
            count     = (k == 0) ? 5'd0 : 5'd1;
            start = 1'b1;
            tick();
            start = 1'b0;
            checks++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL illegal%0d_err got err=%b busy=%b want 1 0", k, err, busy);
            end
            tick();
            checks++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL illegal%0d_pulse got err=%b busy=%b want 0 0", k, err, busy);
            end
        end
        checks++;
        if (cs_cnt != c0) begin failures++; $display("FAIL illegal_cs got %0d issues want 0", cs_cnt - c0); end
    endtask

    task automatic test_start_busy();
        int d0, c0, dn0, e0;
        bit ok;
        d0 = data_q.size(); c0 = cs_cnt; dn0 = done_cnt; e0 = err_cnt;
        out_ready = 1'b1; base_addr = 4'd2; count = 5'd3; start = 1'b1;
        tick();
        base_addr = 4'd5; count = 5'd1;   // second start during ISSUE
        tick();
        start = 1'b0;
        wait_done(30, ok);
        repeat (6) tick();
        checks++;
        if (!ok || data_q.size() - d0 != 3 || done_cnt - dn0 != 1 || err_cnt != e0 || cs_cnt - c0 != 3) begin
            failures++;
            $display("FAIL busy_start got done=%b words=%0d dones=%0d errs=%0d issues=%0d want 1 3 1 0 3",
                     ok, data_q.size() - d0, done_cnt - dn0, err_cnt - e0, cs_cnt - c0);
        end else begin
            checks++;
            if (data_q[d0] !== 10'h102 || data_q[d0+1] !== 10'h103 || data_q[d0+2] !== 10'h104) begin
                failures++;
                $display("FAIL busy_start_data got %h %h %h want 102 103 104",
                         data_q[d0], data_q[d0+1], data_q[d0+2]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int dn0, c0;
        out_ready = 1'b0; base_addr = 4'd0; count = 5'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL abort_pre got v=%b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_async got v=%b busy=%b want 0 0", out_valid, busy);
        end
        dn0 = done_cnt; c0 = cs_cnt;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) tick();
        checks++;
        if (done_cnt != dn0 || cs_cnt != c0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_quiet got dones=%0d issues=%0d busy=%b want 0 0 0", done_cnt - dn0, cs_cnt - c0, busy);
        end
        test_single();
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_illegal();
        test_start_busy();
        test_reset_abort();
        checks++;
        if (both_cnt != 0) begin failures++; $display("FAIL done_err_overlap got %0d cycles want 0", both_cnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
